mem_stage: RTL

- Memory-access pipeline stage between execute and write-back.
- Accepts one EX bundle at a time: ALU result pass-through, load, or store.
- Issues load/store requests over a valid/ready memory port and waits for load data.
- Presents a write-back bundle (dst_reg, data, wr_en) to the write-back stage under valid/ready.

---
 rtl/mem_stage_if.sv | 50 +++++
 rtl/mem_stage.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Bundle of the stage's three handshake channels: EX input, memory port, write-back output.
// master = the memory stage itself; slave = the surrounding pipeline and memory.
// Pure wiring, no latency; every channel is valid/ready.
interface mem_stage_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int REG_W  = 4
);
    logic              ex_valid;
    logic              ex_ready;
    logic [1:0]        ex_op;
    logic [REG_W-1:0]  ex_dst_reg;
    logic              ex_wr_en;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] ex_store_data;
    logic [1:0]        ex_size;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [1:0]        mem_req_size;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    logic              wb_valid;
    logic              wb_ready;
    logic [REG_W-1:0]  wb_dst_reg;
    logic              wb_wr_en;
    logic [DATA_W-1:0] wb_data;

    modport master (
        input  ex_valid, ex_op, ex_dst_reg, ex_wr_en, ex_result, ex_store_data, ex_size,
        output ex_ready,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_size,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output wb_valid, wb_dst_reg, wb_wr_en, wb_data,
        input  wb_ready
    );

    modport slave (
        output ex_valid, ex_op, ex_dst_reg, ex_wr_en, ex_result, ex_store_data, ex_size,
        input  ex_ready,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_size,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  wb_valid, wb_dst_reg, wb_wr_en, wb_data,
        output wb_ready
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: ALU pass-through, load or store, one bundle resident, result to write-back.
// Latency: ALU/NOP 1 cycle; store 2 cycles with ready memory; load = response cycle + 1.
// Backpressure: ex_ready low while busy; wb held stable until wb_ready; optional stall counter (MEM_STALL_CNT_EN).
module mem_stage #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int REG_W  = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_stage_if.master  bus,
    output logic [31:0]  stall_cycles
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] OP_ALU   = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    state_t            state, state_nxt;
    logic              is_store_q;
    logic [REG_W-1:0]  dst_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        size_q;

    logic ex_ready_c;
    logic accept;
    logic is_mem_op;
    logic resp_hit;

    // Keep only the low 1/2/4/8 bytes; upper bits zero.
    function automatic logic [DATA_W-1:0] size_mask(input logic [DATA_W-1:0] v, input logic [1:0] sz);
        case (sz)
            2'd0:    return {{(DATA_W-8){1'b0}},  v[7:0]};
            2'd1:    return {{(DATA_W-16){1'b0}}, v[15:0]};
            2'd2:    return {{(DATA_W-32){1'b0}}, v[31:0]};
            default: return v;
        endcase
    endfunction

    assign ex_ready_c = (state == IDLE) || ((state == DONE) && bus.wb_ready);
    assign accept     = bus.ex_valid && ex_ready_c;
    assign is_mem_op  = (bus.ex_op == OP_LOAD) || (bus.ex_op == OP_STORE);
    // Responses outside WAIT (stray, or left over from before a reset) are dropped.
    assign resp_hit   = (state == WAIT) && bus.mem_resp_valid;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state; DONE may hand straight over to a new bundle without an IDLE bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (state == DONE && bus.wb_ready) state_nxt = IDLE;
                if (accept) state_nxt = is_mem_op ? ISSUE : DONE;
            end
            ISSUE: if (bus.mem_req_ready) state_nxt = is_store_q ? DONE : WAIT;
            WAIT:  if (bus.mem_resp_valid) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bundle capture on accept; load data captured on the response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_store_q <= 1'b0;
            dst_q      <= '0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            size_q     <= '0;
        end else if (accept) begin
            is_store_q <= (bus.ex_op == OP_STORE);
            dst_q      <= bus.ex_dst_reg;
            // Stores retire as a write-back token and NOPs never write.
            wr_en_q    <= bus.ex_wr_en && ((bus.ex_op == OP_ALU) || (bus.ex_op == OP_LOAD));
            addr_q     <= bus.ex_result[ADDR_W-1:0];
            wdata_q    <= size_mask(bus.ex_store_data, bus.ex_size);
            data_q     <= is_mem_op ? '0 : bus.ex_result;
            size_q     <= bus.ex_size;
        end else if (resp_hit) begin
            data_q     <= size_mask(bus.mem_resp_rdata, size_q);
        end
    end

    // Outputs are qualified by state so idle buses read as zero.
    always_comb begin
        bus.ex_ready      = ex_ready_c;
        bus.mem_req_valid = (state == ISSUE);
        bus.mem_req_we    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_wdata = '0;
        bus.mem_req_size  = '0;
        bus.wb_valid      = (state == DONE);
        bus.wb_dst_reg    = '0;
        bus.wb_wr_en      = 1'b0;
        bus.wb_data       = '0;
        if (state == ISSUE) begin
            bus.mem_req_we    = is_store_q;
            bus.mem_req_addr  = addr_q;
            bus.mem_req_wdata = wdata_q;
            bus.mem_req_size  = size_q;
        end
        if (state == DONE) begin
            bus.wb_dst_reg = dst_q;
            bus.wb_wr_en   = wr_en_q;
            bus.wb_data    = data_q;
        end
    end

`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_q;

    // Count cycles spent waiting on memory, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (((state == ISSUE) && !bus.mem_req_ready) ||
                     ((state == WAIT) && !bus.mem_resp_valid)) begin
            if (stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif
endmodule
